// File: rtl/barrier12_ctl_if.sv
// Channel-side bundle for the twelve-way barrier: arm/abort controls, mask,
// per-channel ready, timeout, and the completion/diagnostic outputs.
interface barrier12_ctl_if #(parameter int unsigned TO_W = 8);
    logic            en;
    logic            clr;
    logic [11:0]     msk;
    logic [11:0]     rdy;
    logic [TO_W-1:0] tmo;
    logic            z0;
    logic            to;
    logic            armed;
    logic [11:0]     pend;

    modport master (output en, clr, msk, rdy, tmo, input z0, to, armed, pend);
    modport slave  (input en, clr, msk, rdy, tmo, output z0, to, armed, pend);
endinterface

// File: rtl/barrier12_ctl.sv
// Twelve-way barrier synchroniser: sticky per-channel ready flags, single-cycle
// go pulse once every enabled channel reported, optional timeout with diagnostics.
module barrier12_ctl #(
    parameter int unsigned TO_W = 8
) (
    input  logic           ck,
    input  logic           cdn,
    barrier12_ctl_if.slave bus
);
    localparam int unsigned NCH = 12;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_FIRE = 2'd2;

    logic [1:0]      state, state_nxt;
    logic [NCH-1:0]  mask_r, mask_nxt;
    logic [NCH-1:0]  sticky, sticky_nxt;
    logic [TO_W-1:0] tmo_r, tmo_nxt;
    logic [TO_W-1:0] cnt, cnt_nxt;
    logic            z0_r, z0_nxt;
    logic            to_r, to_nxt;
    logic            armed_r, armed_nxt;
    logic            done_c;

    // Ready seen this cycle counts as reported, so completion needs no extra cycle.
    assign done_c = &(sticky | bus.rdy | ~mask_r);

    // State register
    always_ff @(posedge ck or negedge cdn) begin
        if (!cdn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge ck or negedge cdn) begin
        if (!cdn) begin
            mask_r  <= '0;
            sticky  <= '0;
            tmo_r   <= '0;
            cnt     <= '0;
            z0_r    <= 1'b0;
            to_r    <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            mask_r  <= mask_nxt;
            sticky  <= sticky_nxt;
            tmo_r   <= tmo_nxt;
            cnt     <= cnt_nxt;
            z0_r    <= z0_nxt;
            to_r    <= to_nxt;
            armed_r <= armed_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt  = state;
        mask_nxt   = mask_r;
        sticky_nxt = sticky;
        tmo_nxt    = tmo_r;
        cnt_nxt    = cnt;
        z0_nxt     = 1'b0;
        to_nxt     = 1'b0;

        if (bus.clr) begin
            state_nxt  = S_IDLE;
            sticky_nxt = '0;
            mask_nxt   = '0;
            cnt_nxt    = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.en) begin
                        state_nxt  = S_ARM;
                        mask_nxt   = bus.msk;
                        tmo_nxt    = bus.tmo;
                        sticky_nxt = '0;
                        cnt_nxt    = '0;
                    end
                end
                S_ARM: begin
                    sticky_nxt = sticky | (bus.rdy & mask_r);
                    cnt_nxt    = (cnt == '1) ? cnt : cnt + TO_W'(1);
                    // Completion takes priority over a coincident timeout.
                    if (done_c) begin
                        state_nxt = S_FIRE;
                        z0_nxt    = 1'b1;
                    end else if ((tmo_r != '0) && (cnt == tmo_r - TO_W'(1))) begin
                        state_nxt = S_IDLE;
                        to_nxt    = 1'b1;
                    end
                end
                S_FIRE: begin
                    sticky_nxt = '0;
                    if (bus.en) begin
                        state_nxt = S_ARM;
                        mask_nxt  = bus.msk;
                        tmo_nxt   = bus.tmo;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign armed_nxt = (state_nxt == S_ARM);

    assign bus.z0    = z0_r;
    assign bus.to    = to_r;
    assign bus.armed = armed_r;
    assign bus.pend  = mask_r & ~sticky;
endmodule

// File: tb/tb_barrier12_ctl.sv
// Directed self-checking bench for barrier12_ctl: barrier completion, masking,
// timeout, abort, back-to-back re-arm and asynchronous reset.
module tb_barrier12_ctl;
    logic ck;
    logic cdn;
    int   n_chk;
    int   n_pass;

    barrier12_ctl_if #(.TO_W(8)) bus ();

    barrier12_ctl #(.TO_W(8)) dut (
        .ck  (ck),
        .cdn (cdn),
        .bus (bus.slave)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one edge and land 1 time unit after it, where outputs are sampled.
    task automatic step();
        @(posedge ck);
        #1;
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        cdn     = 1'b0;
        bus.en  = 1'b0;
        bus.clr = 1'b0;
        bus.msk = 12'h000;
        bus.rdy = 12'h000;
        bus.tmo = 8'd0;

        // Reset state
        #2;
        chk("rst_z0", 32'(bus.z0), 32'd0);
        chk("rst_to", 32'(bus.to), 32'd0);
        chk("rst_armed", 32'(bus.armed), 32'd0);
        chk("rst_pend", 32'(bus.pend), 32'h000);
        step();
        step();
        #2 cdn = 1'b1;

        // Basic barrier, one channel per cycle
        bus.msk = 12'hFFF;
        bus.tmo = 8'd0;
        bus.en  = 1'b1;
        step();
        bus.en = 1'b0;
        chk("basic_armed", 32'(bus.armed), 32'd1);
        chk("basic_pend0", 32'(bus.pend), 32'hFFF);
        for (int i = 0; i < 12; i++) begin
            bus.rdy = 12'(1 << i);
            step();
            if (i < 11) begin
                chk("basic_pend", 32'(bus.pend), 32'hFFF & ~((32'd1 << (i + 1)) - 32'd1));
                chk("basic_noz0", 32'(bus.z0), 32'd0);
            end
        end
        bus.rdy = 12'h000;
        chk("basic_z0", 32'(bus.z0), 32'd1);
        chk("basic_fire_armed", 32'(bus.armed), 32'd0);
        chk("basic_fire_pend", 32'(bus.pend), 32'h000);
        step();
        chk("basic_z0_off", 32'(bus.z0), 32'd0);
        chk("basic_idle_armed", 32'(bus.armed), 32'd0);
        chk("basic_idle_pend", 32'(bus.pend), 32'hFFF);

        // Unmasked channels are ignored
        bus.msk = 12'h00F;
        bus.en  = 1'b1;
        step();
        bus.en  = 1'b0;
        bus.rdy = 12'hFF0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("mask_noz0", 32'(bus.z0), 32'd0);
            chk("mask_pend", 32'(bus.pend), 32'h00F);
        end
        bus.rdy = 12'h00F;
        step();
        bus.rdy = 12'h000;
        chk("mask_z0", 32'(bus.z0), 32'd1);
        step();
        chk("mask_z0_off", 32'(bus.z0), 32'd0);

        // Empty mask completes immediately
        bus.msk = 12'h000;
        bus.en  = 1'b1;
        step();
        bus.en = 1'b0;
        chk("empty_armed", 32'(bus.armed), 32'd1);
        chk("empty_noz0", 32'(bus.z0), 32'd0);
        step();
        chk("empty_z0", 32'(bus.z0), 32'd1);
        step();
        chk("empty_z0_off", 32'(bus.z0), 32'd0);

        // Timeout after 5 ARM edges with channel 1 missing
        bus.msk = 12'h003;
        bus.tmo = 8'd5;
        bus.en  = 1'b1;
        step();
        bus.en  = 1'b0;
        bus.rdy = 12'h001;
        for (int i = 1; i <= 5; i++) begin
            step();
            bus.rdy = 12'h000;
            if (i < 5) begin
                chk("tmo_wait_to", 32'(bus.to), 32'd0);
                chk("tmo_wait_armed", 32'(bus.armed), 32'd1);
            end
        end
        chk("tmo_to", 32'(bus.to), 32'd1);
        chk("tmo_armed", 32'(bus.armed), 32'd0);
        chk("tmo_noz0", 32'(bus.z0), 32'd0);
        chk("tmo_pend", 32'(bus.pend), 32'h002);
        step();
        chk("tmo_to_off", 32'(bus.to), 32'd0);
        chk("tmo_pend_hold", 32'(bus.pend), 32'h002);
        step();
        chk("tmo_pend_hold2", 32'(bus.pend), 32'h002);

        // Completion on the timeout edge wins
        bus.en = 1'b1;
        step();
        bus.en  = 1'b0;
        bus.rdy = 12'h001;
        step();
        bus.rdy = 12'h000;
        step();
        step();
        step();
        bus.rdy = 12'h002;
        step();
        bus.rdy = 12'h000;
        chk("race_z0", 32'(bus.z0), 32'd1);
        chk("race_to", 32'(bus.to), 32'd0);
        step();
        chk("race_z0_off", 32'(bus.z0), 32'd0);
        chk("race_to_off", 32'(bus.to), 32'd0);

        // Abort mid-barrier
        bus.msk = 12'hFFF;
        bus.tmo = 8'd0;
        bus.en  = 1'b1;
        step();
        bus.en  = 1'b0;
        bus.rdy = 12'h03F;
        step();
        bus.rdy = 12'h000;
        chk("abort_pend_pre", 32'(bus.pend), 32'hFC0);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        chk("abort_armed", 32'(bus.armed), 32'd0);
        chk("abort_pend", 32'(bus.pend), 32'h000);
        chk("abort_z0", 32'(bus.z0), 32'd0);
        chk("abort_to", 32'(bus.to), 32'd0);
        bus.rdy = 12'hFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_rdy_noz0", 32'(bus.z0), 32'd0);
            chk("abort_rdy_armed", 32'(bus.armed), 32'd0);
        end
        bus.rdy = 12'h000;

        // Back-to-back barriers with EN held
        bus.msk = 12'hFFF;
        bus.rdy = 12'hFFF;
        bus.en  = 1'b1;
        step();
        chk("rearm_arm_z0", 32'(bus.z0), 32'd0);
        chk("rearm_arm", 32'(bus.armed), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rearm_fire_z0", 32'(bus.z0), 32'd1);
            chk("rearm_fire_armed", 32'(bus.armed), 32'd0);
            step();
            chk("rearm_arm_z0", 32'(bus.z0), 32'd0);
            chk("rearm_arm", 32'(bus.armed), 32'd1);
        end

        // Asynchronous reset mid-ARM, between edges
        bus.rdy = 12'h000;
        bus.en  = 1'b0;
        #1;
        chk("areset_pre_armed", 32'(bus.armed), 32'd1);
        chk("areset_pre_pend", 32'(bus.pend), 32'hFFF);
        cdn = 1'b0;
        #1;
        chk("areset_z0", 32'(bus.z0), 32'd0);
        chk("areset_to", 32'(bus.to), 32'd0);
        chk("areset_armed", 32'(bus.armed), 32'd0);
        chk("areset_pend", 32'(bus.pend), 32'h000);
        step();
        #2 cdn = 1'b1;
        step();
        chk("post_reset_armed", 32'(bus.armed), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
